// File: rtl/cpu_defs.sv
// Shared CPU definitions for address translation: lookup/byte types, CSR view,
// TLB entry layout, exception codes and the per-page translate/permission helpers.
package cpu_defs;

  localparam int DMW_MAX = 2;
  localparam logic [5:0] PS_2M = 6'd21;

  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_TLBR = 6'h3f;

  typedef enum logic [1:0] {FETCH, LOAD, STORE} tlb_lookup_type_t;
  typedef enum logic [1:0] {BYTE, HALF_WORD, WORD} byte_type_t;
  typedef enum logic [1:0] {IDLE, SCAN, RESP} addr_trans_state_t;

  typedef struct packed {
    logic       valid;
    logic [5:0] ecode;
    logic [31:0] badv;
  } excp_pass_t;

  typedef struct packed {
    logic [1:0] plv;
    logic       da;
    logic [1:0] datf;
    logic [1:0] datm;
  } crmd_t;

  typedef struct packed {
    logic [3:0] plv;
    logic [1:0] mat;
    logic [2:0] pseg;
    logic [2:0] vseg;
  } dmw_t;

  typedef struct packed {
    crmd_t               crmd;
    logic [9:0]          asid;
    dmw_t [DMW_MAX-1:0]  dmw;
  } csr_t;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic [19:0] ppn0;
    logic [19:0] ppn1;
    logic        v0;
    logic        v1;
    logic        d0;
    logic        d1;
    logic [1:0]  plv0;
    logic [1:0]  plv1;
    logic [1:0]  mat0;
    logic [1:0]  mat1;
  } utlb_entry_t;

  typedef utlb_entry_t tlb_entry_t;

  typedef struct packed {
    logic [31:0] pa;
    logic [1:0]  mat;
    excp_pass_t  excp;
  } trans_result_t;

  function automatic logic tag_match(utlb_entry_t e, logic [18:0] vppn, logic [9:0] asid);
    logic vppn_eq;
    vppn_eq = (e.ps == PS_2M) ? (e.vppn[18:9] == vppn[18:9]) : (e.vppn == vppn);
    return vppn_eq && (e.g || (e.asid == asid));
  endfunction

  // PS selects both the odd/even page bit and where the PPN/offset split falls.
  function automatic trans_result_t page_translate(utlb_entry_t e, logic [31:0] va,
                                                   tlb_lookup_type_t lt, logic [1:0] plv);
    trans_result_t r;
    logic          odd;
    logic          v;
    logic          d;
    logic [1:0]    pplv;
    logic [19:0]   ppn;
    odd  = (e.ps == PS_2M) ? va[21] : va[12];
    ppn  = odd ? e.ppn1 : e.ppn0;
    v    = odd ? e.v1 : e.v0;
    d    = odd ? e.d1 : e.d0;
    pplv = odd ? e.plv1 : e.plv0;
    r.pa   = (e.ps == PS_2M) ? {ppn[19:9], va[20:0]} : {ppn, va[11:0]};
    r.mat  = odd ? e.mat1 : e.mat0;
    r.excp = '0;
    if (!v) begin
      r.excp.valid = 1'b1;
      r.excp.ecode = (lt == FETCH) ? ECODE_PIF : (lt == STORE) ? ECODE_PIS : ECODE_PIL;
    end else if (plv > pplv) begin
      r.excp.valid = 1'b1;
      r.excp.ecode = ECODE_PPI;
    end else if ((lt == STORE) && !d) begin
      r.excp.valid = 1'b1;
      r.excp.ecode = ECODE_PME;
    end
    r.excp.badv = r.excp.valid ? va : 32'd0;
    return r;
  endfunction

endpackage

// File: rtl/utlb_array.sv
// Micro-TLB: small fully associative entry store with parallel tag compare,
// round-robin refill pointer and a whole-array invalidate.
module utlb_array
  import cpu_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [18:0] lookup_vppn,
  input  logic [9:0]  lookup_asid,
  output logic        hit,
  output utlb_entry_t hit_entry,
  input  logic        refill,
  input  utlb_entry_t refill_entry,
  input  logic        inv
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  utlb_entry_t            entries [DEPTH];
  logic [DEPTH-1:0]       valid;
  logic [PTR_W-1:0]       ptr;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      ptr   <= '0;
    end else if (inv) begin
      valid <= '0;
    end else if (refill) begin
      valid[ptr] <= 1'b1;
      ptr        <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  // NOTE: the entry payload has no reset; the valid bits alone make it safe.
  always_ff @(posedge clk) begin
    if (refill && !inv) entries[ptr] <= refill_entry;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit       = 1'b0;
    hit_entry = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && tag_match(entries[i], lookup_vppn, lookup_asid)) begin
        hit       = 1'b1;
        hit_entry = entries[i];
      end
    end
  end

endmodule

// File: rtl/addr_trans_pipe.sv
// Handshaked VA->PA translator: direct mode, DMW, micro-TLB, then main TLB scan.
// Optional feature: define ADDR_TRANS_DMW_EN to enable the direct-map window path.
module addr_trans_pipe
  import cpu_defs::*;
#(
  parameter int TLB_ENTRY_NUM = 16,
  parameter int UTLB_DEPTH    = 4,
  parameter int SCAN_WIDTH    = 4,
  parameter int DMW_NUM       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_va,
  input  tlb_lookup_type_t req_lookup_type,
  input  byte_type_t       req_byte_type,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_pa,
  output logic [1:0]       rsp_mat,
  output excp_pass_t       rsp_excp,
  input  logic             flush,
  input  logic             tlb_update,
  input  csr_t             rd_csr,
  input  tlb_entry_t       tlb_entrys [TLB_ENTRY_NUM]
);
  localparam int GROUPS = TLB_ENTRY_NUM / SCAN_WIDTH;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int IDX_W  = (TLB_ENTRY_NUM > 1) ? $clog2(TLB_ENTRY_NUM) : 1;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(GROUPS - 1);

  addr_trans_state_t state;
  logic [GRP_W-1:0]  grp;
  logic [31:0]       va_q;
  tlb_lookup_type_t  lt_q;

  logic          accept;
  logic          utlb_hit_raw;
  logic          utlb_hit;
  utlb_entry_t   utlb_hit_entry;
  logic          misalign;
  logic          dmw_hit;
  logic [31:0]   dmw_pa;
  logic [1:0]    dmw_mat;
  logic          cls_resp;
  trans_result_t cls_res;
  logic          scan_hit;
  utlb_entry_t   scan_entry;
  trans_result_t scan_res;
  logic          refill;

  assign req_ready = ~flush & ((state == IDLE) | ((state == RESP) & rsp_ready));
  assign accept    = req_valid & req_ready;
  // A lookup in the same cycle as an invalidate must treat the micro-TLB as empty.
  assign utlb_hit  = utlb_hit_raw & ~tlb_update;
  assign refill    = (state == SCAN) & scan_hit & ~flush & ~tlb_update;

  utlb_array #(.DEPTH(UTLB_DEPTH)) u_utlb (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_vppn  (req_va[31:13]),
    .lookup_asid  (rd_csr.asid),
    .hit          (utlb_hit_raw),
    .hit_entry    (utlb_hit_entry),
    .refill       (refill),
    .refill_entry (scan_entry),
    .inv          (tlb_update)
  );

`ifdef ADDR_TRANS_DMW_EN
  always_comb begin
    dmw_hit = 1'b0;
    dmw_pa  = '0;
    dmw_mat = '0;
    for (int i = DMW_NUM - 1; i >= 0; i--) begin
      if ((req_va[31:29] == rd_csr.dmw[i].vseg) && rd_csr.dmw[i].plv[rd_csr.crmd.plv]) begin
        dmw_hit = 1'b1;
        dmw_pa  = {rd_csr.dmw[i].pseg, req_va[28:0]};
        dmw_mat = rd_csr.dmw[i].mat;
      end
    end
  end
`else
  localparam int dmw_num_unused = DMW_NUM;
  logic dmw_unused;
  assign dmw_unused = ^rd_csr.dmw;
  assign dmw_hit    = 1'b0;
  assign dmw_pa     = '0;
  assign dmw_mat    = '0;
`endif

  always_comb begin
    misalign = ((req_byte_type == HALF_WORD) && req_va[0]) ||
               ((req_byte_type == WORD) && (req_va[1:0] != 2'b00));
    cls_resp = 1'b1;
    cls_res  = '0;
    if (misalign) begin
      cls_res.excp.valid = 1'b1;
      cls_res.excp.ecode = ECODE_ALE;
      cls_res.excp.badv  = req_va;
    end else if (rd_csr.crmd.da) begin
      cls_res.pa  = req_va;
      cls_res.mat = (req_lookup_type == FETCH) ? rd_csr.crmd.datf : rd_csr.crmd.datm;
    end else if (dmw_hit) begin
      cls_res.pa  = dmw_pa;
      cls_res.mat = dmw_mat;
    end else if (utlb_hit) begin
      cls_res = page_translate(utlb_hit_entry, req_va, req_lookup_type, rd_csr.crmd.plv);
    end else begin
      cls_resp = 1'b0;
    end
  end

  always_comb begin
    scan_hit   = 1'b0;
    scan_entry = '0;
    for (int i = SCAN_WIDTH - 1; i >= 0; i--) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'(grp * SCAN_WIDTH + i);
      if (tag_match(tlb_entrys[idx], va_q[31:13], rd_csr.asid)) begin
        scan_hit   = 1'b1;
        scan_entry = tlb_entrys[idx];
      end
    end
    scan_res = page_translate(scan_entry, va_q, lt_q, rd_csr.crmd.plv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grp       <= '0;
      va_q      <= '0;
      lt_q      <= LOAD;
      rsp_valid <= 1'b0;
      rsp_pa    <= '0;
      rsp_mat   <= '0;
      rsp_excp  <= '0;
    end else if (flush) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end else if (accept) begin
      va_q <= req_va;
      lt_q <= req_lookup_type;
      grp  <= '0;
      if (cls_resp) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_pa    <= cls_res.pa;
        rsp_mat   <= cls_res.mat;
        rsp_excp  <= cls_res.excp;
      end else begin
        state     <= SCAN;
        rsp_valid <= 1'b0;
      end
    end else begin
      case (state)
        SCAN: begin
          if (tlb_update) begin
            grp <= '0;
          end else if (scan_hit) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_pa    <= scan_res.pa;
            rsp_mat   <= scan_res.mat;
            rsp_excp  <= scan_res.excp;
          end else if (grp == LAST_GRP) begin
            state          <= RESP;
            rsp_valid      <= 1'b1;
            rsp_pa         <= '0;
            rsp_mat        <= '0;
            rsp_excp.valid <= 1'b1;
            rsp_excp.ecode <= ECODE_TLBR;
            rsp_excp.badv  <= va_q;
          end else begin
            grp <= grp + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_trans_pipe.sv
// Directed bench for addr_trans_pipe: single-transaction vector table plus
// hand-written sequences for scan latency, refill, hold, invalidate and flush.
module tb_addr_trans_pipe;
  import cpu_defs::*;

  localparam int TLB_N = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_va;
  tlb_lookup_type_t req_lookup_type;
  byte_type_t       req_byte_type;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_pa;
  logic [1:0]       rsp_mat;
  excp_pass_t       rsp_excp;
  logic             flush;
  logic             tlb_update;
  csr_t             rd_csr;
  tlb_entry_t       tlb_entrys [TLB_N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addr_trans_pipe dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_va          (req_va),
    .req_lookup_type (req_lookup_type),
    .req_byte_type   (req_byte_type),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_pa          (rsp_pa),
    .rsp_mat         (rsp_mat),
    .rsp_excp        (rsp_excp),
    .flush           (flush),
    .tlb_update      (tlb_update),
    .rd_csr          (rd_csr),
    .tlb_entrys      (tlb_entrys)
  );

  typedef struct {
    string            name;
    logic             da;
    logic [1:0]       plv;
    logic [31:0]      va;
    tlb_lookup_type_t lt;
    byte_type_t       bt;
    int               lat;
    logic [31:0]      pa;
    logic [1:0]       mat;
    logic             ev;
    logic [5:0]       ecode;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [38:0] mk_excp(input logic ev, input logic [5:0] ec, input logic [31:0] va);
    return ev ? {1'b1, ec, va} : 39'd0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one request, returns the cycle count from acceptance to rsp_valid.
  task automatic issue(input logic [31:0] va, input tlb_lookup_type_t lt, input byte_type_t bt,
                       output int lat);
    req_va          = va;
    req_lookup_type = lt;
    req_byte_type   = bt;
    req_valid       = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic pulse_update();
    tlb_update = 1'b1;
    tick(1);
    tlb_update = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic seen;

    rst_n           = 1'b0;
    req_valid       = 1'b0;
    req_va          = '0;
    req_lookup_type = LOAD;
    req_byte_type   = WORD;
    rsp_ready       = 1'b1;
    flush           = 1'b0;
    tlb_update      = 1'b0;
    rd_csr          = '0;
    rd_csr.asid     = 10'd1;
    rd_csr.crmd.datf = 2'd2;
    rd_csr.crmd.datm = 2'd1;
    rd_csr.dmw[0].vseg = 3'd5;
    rd_csr.dmw[0].pseg = 3'd0;
    rd_csr.dmw[0].plv  = 4'b0001;
    rd_csr.dmw[0].mat  = 2'd1;
    rd_csr.dmw[1].vseg = 3'd5;
    rd_csr.dmw[1].pseg = 3'd7;
    rd_csr.dmw[1].plv  = 4'b1111;
    rd_csr.dmw[1].mat  = 2'd2;
    for (int i = 0; i < TLB_N; i++) tlb_entrys[i] = '0;
    tlb_entrys[9].vppn = 19'h1234;
    tlb_entrys[9].ps   = 6'd12;
    tlb_entrys[9].g    = 1'b1;
    tlb_entrys[9].ppn0 = 20'h00567;
    tlb_entrys[9].v0   = 1'b1;
    tlb_entrys[9].d0   = 1'b1;
    tlb_entrys[9].mat0 = 2'd1;
    tlb_entrys[5].vppn = 19'h2000;
    tlb_entrys[5].ps   = 6'd12;
    tlb_entrys[5].g    = 1'b1;
    tlb_entrys[5].ppn0 = 20'h000ab;
    tlb_entrys[5].v0   = 1'b1;
    tlb_entrys[5].d0   = 1'b1;
    tlb_entrys[5].mat0 = 2'd1;

    vecs[0] = '{"ale_word",  1'b0, 2'd0, 32'h0000_1002, LOAD,  WORD,      1, 32'h0, 2'd0, 1'b1, 6'h09};
    vecs[1] = '{"ale_half",  1'b1, 2'd0, 32'h1c00_0001, LOAD,  HALF_WORD, 1, 32'h0, 2'd0, 1'b1, 6'h09};
    vecs[2] = '{"da_byte",   1'b1, 2'd0, 32'h1c00_0003, LOAD,  BYTE,      1, 32'h1c00_0003, 2'd1, 1'b0, 6'h00};
    vecs[3] = '{"da_fetch",  1'b1, 2'd0, 32'h1c00_0000, FETCH, WORD,      1, 32'h1c00_0000, 2'd2, 1'b0, 6'h00};
    vecs[4] = '{"da_load",   1'b1, 2'd0, 32'h1c00_0000, LOAD,  WORD,      1, 32'h1c00_0000, 2'd1, 1'b0, 6'h00};
    vecs[5] = '{"da_store",  1'b1, 2'd3, 32'h1c00_0002, STORE, HALF_WORD, 1, 32'h1c00_0002, 2'd1, 1'b0, 6'h00};
`ifdef ADDR_TRANS_DMW_EN
    vecs[6] = '{"dmw0",      1'b0, 2'd0, 32'ha000_0040, LOAD,  WORD,      1, 32'h0000_0040, 2'd1, 1'b0, 6'h00};
    vecs[7] = '{"dmw1_plv3", 1'b0, 2'd3, 32'ha000_0040, LOAD,  WORD,      1, 32'he000_0040, 2'd2, 1'b0, 6'h00};
`else
    vecs[6] = '{"nodmw_tlbr",  1'b0, 2'd0, 32'ha000_0040, LOAD, WORD,     5, 32'h0, 2'd0, 1'b1, 6'h3f};
    vecs[7] = '{"nodmw_tlbr3", 1'b0, 2'd3, 32'ha000_0040, LOAD, WORD,     5, 32'h0, 2'd0, 1'b1, 6'h3f};
`endif

    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_pa", rsp_pa, 0);
    check("reset_rsp_mat", rsp_mat, 0);
    check("reset_rsp_excp", rsp_excp, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("idle_req_ready", req_ready, 1);

    for (int i = 0; i < 8; i++) begin
      rd_csr.crmd.da  = vecs[i].da;
      rd_csr.crmd.plv = vecs[i].plv;
      issue(vecs[i].va, vecs[i].lt, vecs[i].bt, lat);
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      check({vecs[i].name, "_pa"}, rsp_pa, vecs[i].pa);
      check({vecs[i].name, "_mat"}, rsp_mat, vecs[i].mat);
      check({vecs[i].name, "_excp"}, rsp_excp, mk_excp(vecs[i].ev, vecs[i].ecode, vecs[i].va));
      tick(2);
    end

    rd_csr.crmd.da  = 1'b0;
    rd_csr.crmd.plv = 2'd0;

    // Main TLB hit in group 2, then the refilled micro-TLB.
    issue(32'h0246_8010, LOAD, WORD, lat);
    check("scan_hit_lat", lat, 4);
    check("scan_hit_pa", rsp_pa, 32'h0056_7010);
    check("scan_hit_mat", rsp_mat, 1);
    check("scan_hit_excp", rsp_excp, 0);
    tick(2);
    issue(32'h0246_8010, LOAD, WORD, lat);
    check("utlb_hit_lat", lat, 1);
    check("utlb_hit_pa", rsp_pa, 32'h0056_7010);
    tick(2);

    // Odd page of the same entry is invalid.
    issue(32'h0246_9010, LOAD, WORD, lat);
    check("pil_lat", lat, 1);
    check("pil_excp", rsp_excp, mk_excp(1'b1, 6'h01, 32'h0246_9010));
    tick(2);
    issue(32'h0246_9010, FETCH, WORD, lat);
    check("pif_excp", rsp_excp, mk_excp(1'b1, 6'h03, 32'h0246_9010));
    tick(2);
    rd_csr.crmd.plv = 2'd3;
    issue(32'h0246_8010, LOAD, WORD, lat);
    check("ppi_lat", lat, 1);
    check("ppi_excp", rsp_excp, mk_excp(1'b1, 6'h07, 32'h0246_8010));
    rd_csr.crmd.plv = 2'd0;
    tick(2);

    // Response held under back-pressure; invalidate while in RESP.
    rsp_ready = 1'b0;
    issue(32'h0246_8010, LOAD, WORD, lat);
    check("hold_lat", lat, 1);
    check("hold_req_ready", req_ready, 0);
    pulse_update();
    check("hold_valid_1", rsp_valid, 1);
    check("hold_pa_1", rsp_pa, 32'h0056_7010);
    tick(1);
    check("hold_valid_2", rsp_valid, 1);
    check("hold_pa_2", rsp_pa, 32'h0056_7010);
    rsp_ready = 1'b1;
    tick(1);
    check("hold_release", rsp_valid, 0);
    tick(1);
    issue(32'h0246_8010, LOAD, WORD, lat);
    check("rescan_after_update_lat", lat, 4);
    check("rescan_after_update_pa", rsp_pa, 32'h0056_7010);
    tick(2);

    // Store to a clean page after the main TLB entry changes.
    tlb_entrys[9].d0 = 1'b0;
    pulse_update();
    issue(32'h0246_8020, STORE, WORD, lat);
    check("pme_lat", lat, 4);
    check("pme_pa", rsp_pa, 32'h0056_7020);
    check("pme_excp", rsp_excp, mk_excp(1'b1, 6'h04, 32'h0246_8020));
    tick(2);

    // Flush in SCAN cycle 2, which would have been the group-1 hit cycle.
    req_va          = 32'h0400_0000;
    req_lookup_type = LOAD;
    req_byte_type   = WORD;
    req_valid       = 1'b1;
    tick(1);
    req_valid = 1'b0;
    check("flush_scan_no_rsp", rsp_valid, 0);
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | rsp_valid;
      tick(1);
    end
    check("flush_no_rsp", seen, 0);
    issue(32'h0400_0000, LOAD, WORD, lat);
    check("after_flush_rescan_lat", lat, 3);
    check("after_flush_rescan_pa", rsp_pa, 32'h000a_b000);
    tick(2);
    issue(32'h0400_0000, LOAD, WORD, lat);
    check("after_flush_utlb_lat", lat, 1);
    tick(2);
    issue(32'h0246_8010, LOAD, WORD, lat);
    check("utlb_kept_lat", lat, 1);
    check("utlb_kept_pa", rsp_pa, 32'h0056_7010);
    tick(2);

    // Back-to-back acceptance while streaming direct-mode responses.
    rd_csr.crmd.da  = 1'b1;
    req_va          = 32'h1000_0000;
    req_lookup_type = LOAD;
    req_byte_type   = WORD;
    req_valid       = 1'b1;
    tick(1);
    check("b2b_first_valid", rsp_valid, 1);
    check("b2b_first_pa", rsp_pa, 32'h1000_0000);
    req_va = 32'h2000_0004;
    tick(1);
    req_valid = 1'b0;
    check("b2b_second_valid", rsp_valid, 1);
    check("b2b_second_pa", rsp_pa, 32'h2000_0004);
    tick(1);
    check("b2b_drain", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
